nibble_deserializer: RTL

- Receiving end of the nibble stream produced by the team's 4-bit shift-register pipeline.
- Accepts one W-bit nibble per cycle over a valid/ready handshake and assembles N consecutive nibbles into one W*N-bit word.
- Presents each assembled word on a registered output with a valid/ready handshake.
- Sits between a nibble-serial source and any word-wide consumer. A separate output holding register lets collection of the next word continue while the consumer stalls.

---
 rtl/nibble_deserializer.sv | 98 +++++++++
 1 files changed

// File: rtl/nibble_deserializer.sv
// ============================================================================
//  Module   : nibble_deserializer
//  Function : Collects N consecutive W-bit nibbles from a valid/ready stream
//             and presents each assembled W*N-bit word on a registered
//             valid/ready output. A separate output holding register lets
//             collection of the next word continue while the consumer stalls.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module nibble_deserializer #(
    parameter int W         = 4,
    parameter int N         = 3,
    parameter int MSB_FIRST = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [W-1:0]         in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [W*N-1:0]       out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [$clog2(N)-1:0] nib_count
);

    localparam int                c_CW   = $clog2(N);
    localparam int                c_WW   = W * N;
    localparam logic [c_CW-1:0]   c_LAST = c_CW'(N - 1);

    logic [c_WW-1:0] r_collect;
    logic [c_CW-1:0] r_count;
    logic [c_WW-1:0] r_out_data;
    logic            r_out_valid;

    logic [c_WW-1:0] w_collect_next;
    logic            w_last;
    logic            w_accept;
    logic            w_complete;
    logic            w_drain;

    assign w_last     = (r_count == c_LAST);
    // A partial nibble is always taken; only the word-completing nibble waits
    // when the holding register still owns an undrained word.
    assign in_ready   = !(w_last && r_out_valid && !out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_complete = w_accept && w_last;
    assign w_drain    = r_out_valid && out_ready;

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            // Shift in at the bottom so the first nibble ends up on top.
            always_comb begin
                w_collect_next = {r_collect[c_WW-W-1:0], in_data};
            end
        end else begin : g_lsb_first
            // Write the nibble into the slot selected by the running count.
            always_comb begin
                w_collect_next = r_collect;
                w_collect_next[W*int'(r_count) +: W] = in_data;
            end
        end
    endgenerate

    // Collect register and nibble counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_collect <= '0;
            r_count   <= '0;
        end else if (w_complete) begin
            r_collect <= '0;
            r_count   <= '0;
        end else if (w_accept) begin
            r_collect <= w_collect_next;
            r_count   <= r_count + 1'b1;
        end
    end

    // Output holding register: load on completion, release on drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_complete) begin
            r_out_data  <= w_collect_next;
            r_out_valid <= 1'b1;
        end else if (w_drain) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign nib_count = r_count;

endmodule

`default_nettype wire
